// File: rtl/alu_cmd_sequencer_pkg.sv
// alu_cmd_sequencer_pkg
//   Shared constants for the UART ALU command sequencer: frame opcodes,
//   RegFile operand addresses and the binary FSM state encoding.
package alu_cmd_sequencer_pkg;

  // Frame opcodes (first byte of a command frame)
  localparam logic [7:0] ALU_W_OP_CMD  = 8'hCC;  // opcode, OpA, OpB, FUNC
  localparam logic [7:0] ALU_WN_OP_CMD = 8'hDD;  // opcode, FUNC

  // RegFile operand slots
  localparam logic [3:0] OPA_ADDR = 4'h0;
  localparam logic [3:0] OPB_ADDR = 4'h1;

  // FSM states, binary encoded
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WAIT_OPA  = 4'd1;
  localparam logic [3:0] S_WR_OPA    = 4'd2;
  localparam logic [3:0] S_WAIT_OPB  = 4'd3;
  localparam logic [3:0] S_WR_OPB    = 4'd4;
  localparam logic [3:0] S_WAIT_FUNC = 4'd5;
  localparam logic [3:0] S_ALU_RUN   = 4'd6;
  localparam logic [3:0] S_WAIT_RES  = 4'd7;
  localparam logic [3:0] S_TX_LSB    = 4'd8;
  localparam logic [3:0] S_TX_MSB    = 4'd9;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Parses ALU command frames from the UART RX byte stream, writes operands
//   into RegFile slots 0x0/0x1, launches the shared ALU with its clock gate
//   open, and pushes the 16-bit result to the TX FIFO LSB first.
// Ports:
//   CLK, RST                 clock, async active-low reset
//   RX_DATA_VALID/IN         one-cycle RX byte strobe and data
//   RegFile_WrEn/ADDRESS/WrData  operand write port
//   ALU_FUNC, ALU_EN, ALU_CLK_EN  ALU control
//   ALU_OUT, ALU_OUT_VALID   ALU result
//   FIFO_FULL, FIFO_WR, TX_DATA_OUT  TX FIFO write port
//   BUSY                     state is not IDLE
//   ERR                      one-cycle pulse on ALU timeout
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH         = 8,
  parameter int ALU_FUNC_WIDTH     = 4,
  parameter int RegFile_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          RX_DATA_VALID,
  input  logic [DATA_WIDTH-1:0]         RX_DATA_IN,
  output logic                          RegFile_WrEn,
  output logic [RegFile_ADDR_WIDTH-1:0] RegFile_ADDRESS,
  output logic [DATA_WIDTH-1:0]         RegFile_WrData,
  output logic [ALU_FUNC_WIDTH-1:0]     ALU_FUNC,
  output logic                          ALU_EN,
  output logic                          ALU_CLK_EN,
  input  logic [2*DATA_WIDTH-1:0]       ALU_OUT,
  input  logic                          ALU_OUT_VALID,
  input  logic                          FIFO_FULL,
  output logic                          FIFO_WR,
  output logic [DATA_WIDTH-1:0]         TX_DATA_OUT,
  output logic                          BUSY,
  output logic                          ERR
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [3:0]                r_state, w_next;
  logic [DATA_WIDTH-1:0]     r_opnd;
  logic [ALU_FUNC_WIDTH-1:0] r_func;
  logic [2*DATA_WIDTH-1:0]   r_res;
  logic [CW-1:0]             r_tcnt;
  logic                      w_res_ok;
  logic                      w_timeout;
  logic                      w_wr_a, w_wr_b, w_tx_l, w_tx_m;

  // Result accepted in ALU_RUN too, so a single-cycle ALU is not penalised.
  assign w_res_ok  = ALU_OUT_VALID && (r_state == S_ALU_RUN || r_state == S_WAIT_RES);
  // Counter holds 0..T-1 across the T cycles of WAIT_RES; valid wins a tie.
  assign w_timeout = (r_state == S_WAIT_RES) && !ALU_OUT_VALID && (r_tcnt == TO_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (RX_DATA_VALID) begin
        if (RX_DATA_IN == DATA_WIDTH'(ALU_W_OP_CMD))       w_next = S_WAIT_OPA;
        else if (RX_DATA_IN == DATA_WIDTH'(ALU_WN_OP_CMD)) w_next = S_WAIT_FUNC;
      end
      S_WAIT_OPA:  if (RX_DATA_VALID) w_next = S_WR_OPA;
      S_WR_OPA:    w_next = S_WAIT_OPB;
      S_WAIT_OPB:  if (RX_DATA_VALID) w_next = S_WR_OPB;
      S_WR_OPB:    w_next = S_WAIT_FUNC;
      S_WAIT_FUNC: if (RX_DATA_VALID) w_next = S_ALU_RUN;
      S_ALU_RUN:   w_next = w_res_ok ? S_TX_LSB : S_WAIT_RES;
      S_WAIT_RES: begin
        if (w_res_ok)       w_next = S_TX_LSB;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_TX_LSB:    if (!FIFO_FULL) w_next = S_TX_MSB;
      S_TX_MSB:    if (!FIFO_FULL) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_opnd  <= '0;
      r_func  <= '0;
      r_res   <= '0;
      r_tcnt  <= '0;
    end else begin
      r_state <= w_next;
      if (RX_DATA_VALID && (r_state == S_WAIT_OPA || r_state == S_WAIT_OPB))
        r_opnd <= RX_DATA_IN;
      if (RX_DATA_VALID && r_state == S_WAIT_FUNC)
        r_func <= RX_DATA_IN[ALU_FUNC_WIDTH-1:0];
      if (w_res_ok)
        r_res <= ALU_OUT;
      // Cleared during ALU_RUN so every WAIT_RES starts from zero.
      if (r_state == S_ALU_RUN)       r_tcnt <= '0;
      else if (r_state == S_WAIT_RES) r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign w_wr_a = (r_state == S_WR_OPA);
  assign w_wr_b = (r_state == S_WR_OPB);
  assign w_tx_l = (r_state == S_TX_LSB);
  assign w_tx_m = (r_state == S_TX_MSB);

  // All outputs decode from registered state, so they drop with async reset.
  assign RegFile_WrEn    = w_wr_a | w_wr_b;
  assign RegFile_ADDRESS = w_wr_a ? RegFile_ADDR_WIDTH'(OPA_ADDR) :
                           w_wr_b ? RegFile_ADDR_WIDTH'(OPB_ADDR) : '0;
  assign RegFile_WrData  = (w_wr_a | w_wr_b) ? r_opnd : '0;
  assign ALU_FUNC        = r_func;
  assign ALU_EN          = (r_state == S_ALU_RUN);
  assign ALU_CLK_EN      = (r_state == S_ALU_RUN) | (r_state == S_WAIT_RES);
  assign FIFO_WR         = (w_tx_l | w_tx_m) & ~FIFO_FULL;
  assign TX_DATA_OUT     = w_tx_l ? r_res[DATA_WIDTH-1:0] :
                           w_tx_m ? r_res[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign BUSY            = (r_state != S_IDLE);
  assign ERR             = w_timeout;

endmodule
